// File: rtl/arbitro_wrr_pkg.sv
// Shared types and helpers for the arbitro_wrr weighted round-robin arbiter.
package arbitro_pkg;

  localparam int DEST_W    = 2;
  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot4 = 4'b0001;
      2'd1:    onehot4 = 4'b0010;
      2'd2:    onehot4 = 4'b0100;
      2'd3:    onehot4 = 4'b1000;
      default: onehot4 = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/arbitro_wrr_select.sv
// Next-candidate search: first non-empty input starting at ptr, wrapping mod 4.
module wrr_select
  import arbitro_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [3:0] fifo_empty,
  output logic [1:0] cand,
  output logic       found
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest non-empty input wins.
  always_comb begin
    cand  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx   = ptr + 2'(k);
      cand  = fifo_empty[idx] ? cand : idx;
      found = found | ~fifo_empty[idx];
    end
  end

endmodule

// File: rtl/arbitro_wrr.sv
// Weighted round-robin arbiter, four input FIFOs to four output FIFOs.
// Optional per-input grant and stall counters under macro ARB_STATS_EN.
module arbitro_wrr
  import arbitro_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int W0 = 4,
  parameter int W1 = 3,
  parameter int W2 = 2,
  parameter int W3 = 1
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            fifo_empty,
  input  logic [3:0]            almost_full,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant_id,
  output logic                  busy
`ifdef ARB_STATS_EN
  ,
  output logic [63:0]           grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            ptr;
  logic [1:0]            ptr_nxt;
  logic [2:0]            credit;
  logic [2:0]            credit_nxt;
  logic [1:0]            sel_q;
  logic                  v1;
  logic [1:0]            cand;
  logic                  found;
  logic                  eligible;
  logic                  pop_en;
  logic [DATA_WIDTH-1:0] word;

  function automatic logic [2:0] weight(input logic [1:0] idx);
    case (idx)
      2'd0:    weight = 3'(W0);
      2'd1:    weight = 3'(W1);
      2'd2:    weight = 3'(W2);
      2'd3:    weight = 3'(W3);
      default: weight = 3'(W0);
    endcase
  endfunction

  wrr_select u_select (
    .ptr        (ptr),
    .fifo_empty (fifo_empty),
    .cand       (cand),
    .found      (found)
  );

  // Pop decision and credit/pointer bookkeeping. Pops are issued from IDLE
  // as well as SERVE so the first word is not delayed; STALL never pops.
  always_comb begin
    eligible   = found && (almost_full == 4'b0000);
    pop_en     = eligible && (state != STALL) && !reset;
    pop        = pop_en ? onehot4(cand) : 4'b0000;
    grant_id   = pop_en ? cand : 2'd0;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    if (!pop_en) begin
      ptr_nxt    = ptr;
      credit_nxt = credit;
    end else if (cand == ptr) begin
      if (credit == 3'd1) begin
        ptr_nxt    = ptr + 2'd1;
        credit_nxt = weight(ptr + 2'd1);
      end else begin
        credit_nxt = credit - 3'd1;
      end
    end else begin
      if (weight(cand) == 3'd1) begin
        ptr_nxt    = cand + 2'd1;
        credit_nxt = weight(cand + 2'd1);
      end else begin
        ptr_nxt    = cand;
        credit_nxt = weight(cand) - 3'd1;
      end
    end
  end

  // Scheduler state transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = eligible ? SERVE : IDLE;
      SERVE: begin
        if (almost_full != 4'b0000) state_nxt = STALL;
        else if (!found)            state_nxt = IDLE;
        else                        state_nxt = SERVE;
      end
      STALL: begin
        if (almost_full != 4'b0000) state_nxt = STALL;
        else if (found)             state_nxt = SERVE;
        else                        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data of the input popped last cycle.
  always_comb begin
    case (sel_q)
      2'd0:    word = data_in0;
      2'd1:    word = data_in1;
      2'd2:    word = data_in2;
      2'd3:    word = data_in3;
      default: word = data_in0;
    endcase
  end

  // Scheduler registers and the two-stage pop-to-push pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      credit   <= 3'(W0);
      sel_q    <= 2'd0;
      v1       <= 1'b0;
      busy     <= 1'b0;
      push     <= 4'b0000;
      data_out <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      sel_q  <= cand;
      v1     <= pop_en;
      busy   <= pop_en | v1;
      push   <= v1 ? onehot4(word[DATA_WIDTH-1 -: DEST_W]) : 4'b0000;
      if (v1) data_out <= word;
      else    data_out <= data_out;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating grant and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= 64'd0;
      stall_cnt <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pop[i] && (grant_cnt[16*i +: 16] != 16'hFFFF))
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      end
      if ((state == STALL) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arbitro_wrr.sv
// Self-checking bench for arbitro_wrr: vector table for pops, scoreboard for pushes.
module tb_arbitro_wrr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fifo_empty = 4'hF;
  logic [3:0] almost_full = 4'h0;
  logic [9:0] data_in0 = 10'd0;
  logic [9:0] data_in1 = 10'd0;
  logic [9:0] data_in2 = 10'd0;
  logic [9:0] data_in3 = 10'd0;
  logic [3:0] pop;
  logic [3:0] push;
  logic [9:0] data_out;
  logic [1:0] grant_id;
  logic       busy;
`ifdef ARB_STATS_EN
  logic [63:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  arbitro_wrr dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .almost_full (almost_full),
    .data_in0    (data_in0),
    .data_in1    (data_in1),
    .data_in2    (data_in2),
    .data_in3    (data_in3),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] fe;
    logic [3:0] af;
    logic       rst;
    logic [3:0] pop;
    logic       chk_busy;
    logic       busy;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] push;
    logic [9:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic ovr = 1'b0;
  int   seq[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

  function automatic logic [9:0] dword(input int p, input int c);
    if (ovr && p == 1) return 10'h205;
    return {2'(p + c), 8'(c * 4 + p)};
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    case (oh)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] fe, input logic [3:0] af, input logic rst,
                     input logic [3:0] p, input logic cb = 1'b0, input logic b = 1'b0);
    vec_t v;
    v.fe = fe; v.af = af; v.rst = rst; v.pop = p; v.chk_busy = cb; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic add_reset();
    add(4'hF, 4'h0, 1'b1, 4'b0000);
    add(4'hF, 4'h0, 1'b1, 4'b0000);
  endtask

  task automatic add_drain();
    for (int i = 0; i < 3; i++) add(4'hF, 4'h0, 1'b0, 4'b0000);
  endtask

  task automatic run_vecs();
    exp_t       e;
    logic [9:0] w;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset       = vecs[i].rst;
      fifo_empty  = vecs[i].fe;
      almost_full = vecs[i].af;
      data_in0    = dword(0, cyc);
      data_in1    = dword(1, cyc);
      data_in2    = dword(2, cyc);
      data_in3    = dword(3, cyc);
      @(negedge clk);
      check("pop", 64'(pop), 64'(vecs[i].pop));
      if (vecs[i].pop != 4'b0000) check("grant_id", 64'(grant_id), 64'(idx_of(vecs[i].pop)));
      if (vecs[i].chk_busy) check("busy", 64'(busy), 64'(vecs[i].busy));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("push", 64'(push), 64'(sb[0].push));
        check("data_out", 64'(data_out), 64'(sb[0].data));
        void'(sb.pop_front());
      end else begin
        check("push_idle", 64'(push), 64'd0);
      end
      if (vecs[i].rst) sb.delete();
      if (vecs[i].pop != 4'b0000 && !vecs[i].rst) begin
        w      = dword(idx_of(vecs[i].pop), cyc + 1);
        e.due  = cyc + 2;
        e.push = 4'b0001 << w[9:8];
        e.data = w;
        sb.push_back(e);
      end
      cyc++;
    end
    vecs.delete();
  endtask

  initial begin
    // Reset with inputs non-empty: no pop may leak out while reset is high.
    add(4'h0, 4'h0, 1'b1, 4'b0000);
    add_reset();
    run_vecs();
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_push", 64'(push), 64'd0);

    // Full load: 10 WRR rounds of P0x4, P1x3, P2x2, P3x1.
    for (int c = 0; c < 100; c++) add(4'h0, 4'h0, 1'b0, 4'b0001 << seq[c % 10]);
    add_drain();
    run_vecs();
`ifdef ARB_STATS_EN
    check("grant_cnt", grant_cnt, {16'd10, 16'd20, 16'd30, 16'd40});
`endif

    // Only P2 non-empty: served every cycle across credit reloads.
    add_reset();
    for (int c = 0; c < 12; c++) add(4'b1011, 4'h0, 1'b0, 4'b0100);
    add_drain();
    run_vecs();

    // Destination decode: 10'h205 from P1 lands on output FIFO 2.
    ovr = 1'b1;
    add_reset();
    add(4'b1101, 4'h0, 1'b0, 4'b0010);
    add_drain();
    run_vecs();
    ovr = 1'b0;

    // Stall with two words in flight; pops resume with ptr/credit intact.
    add_reset();
    add(4'h0, 4'h0, 1'b0, 4'b0001);
    add(4'h0, 4'h0, 1'b0, 4'b0001);
    add(4'h0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
    add(4'h0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
    add(4'h0, 4'h0, 1'b0, 4'b0001);
    add(4'h0, 4'h0, 1'b0, 4'b0001);
    add(4'h0, 4'h0, 1'b0, 4'b0010);
    add(4'h0, 4'h0, 1'b0, 4'b0010);
    add_drain();
    run_vecs();
`ifdef ARB_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    // Reset one cycle after a pop: no push follows, scheduler restarts at P0.
    add_reset();
    add(4'h0, 4'h0, 1'b0, 4'b0001);
    add(4'h0, 4'h0, 1'b1, 4'b0000);
    add(4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
    add(4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) add(4'h0, 4'h0, 1'b0, 4'b0001);
    add(4'h0, 4'h0, 1'b0, 4'b0010);
    add_drain();
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
